// File: rtl/five_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and strobe bit positions for the five_ctrl sequencer.
package five_ctrl_pkg;

    localparam int PC_W_DEF  = 12;
    localparam int INS_W_DEF = 16;
    localparam int OP_W      = 4;

    localparam logic [OP_W-1:0] OP_CLA  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_COM  = 4'h3;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h4;
    localparam logic [OP_W-1:0] OP_CSL  = 4'h5;
    localparam logic [OP_W-1:0] OP_STA  = 4'h6;
    localparam logic [OP_W-1:0] OP_BAN  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_STOP = 4'h9;

    // Bit positions inside the EXEC strobe vector
    localparam int STB_W   = 7;
    localparam int STB_CLR = 0;
    localparam int STB_LD  = 1;
    localparam int STB_ADD = 2;
    localparam int STB_COM = 3;
    localparam int STB_SHR = 4;
    localparam int STB_CSL = 5;
    localparam int STB_WE  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/five_op_decoder.sv
// Combinational opcode classifier: EXEC strobe vector plus instruction-class flags.
module five_op_decoder
    import five_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  opcode,
    output logic [STB_W-1:0] strobes,
    output logic             is_mem,
    output logic             is_branch,
    output logic             is_cond,
    output logic             is_stop,
    output logic             is_illegal
);

    always_comb begin
        strobes    = '0;
        is_mem     = 1'b0;
        is_branch  = 1'b0;
        is_cond    = 1'b0;
        is_stop    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_CLA:  strobes[STB_CLR] = 1'b1;
            OP_LDA: begin
                strobes[STB_LD] = 1'b1;
                is_mem          = 1'b1;
            end
            OP_ADD: begin
                strobes[STB_ADD] = 1'b1;
                is_mem           = 1'b1;
            end
            OP_COM:  strobes[STB_COM] = 1'b1;
            OP_SHR:  strobes[STB_SHR] = 1'b1;
            OP_CSL:  strobes[STB_CSL] = 1'b1;
            OP_STA:  strobes[STB_WE]  = 1'b1;
            OP_BAN: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
            end
            OP_JMP:  is_branch = 1'b1;
            OP_STOP: is_stop   = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/five_ctrl_sequencer.sv
// Fetch/decode/execute sequencer owning PC and IR for the accumulator CPU.
// Define FIVE_CTRL_TRAP_EN to halt with a sticky illegal flag on undefined opcodes.
module five_ctrl_sequencer
    import five_ctrl_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INS_W    = INS_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [INS_W-1:0] ins,
    input  logic             acc_neg,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] ir,
    output logic [PC_W-1:0]  dmem_addr,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             acc_clr,
    output logic             acc_ld,
    output logic             acc_add,
    output logic             acc_com,
    output logic             acc_shr,
    output logic             acc_csl,
    output logic             halted,
    output logic             illegal
);

    localparam logic [PC_W-1:0] RESET_VAL = RESET_PC[PC_W-1:0];

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INS_W-1:0]   ir_reg, ir_next;
    logic [STB_W-1:0]   stb_reg, stb_next;
    logic               re_reg, re_next;
    logic               halted_reg, halted_next;

    logic [STB_W-1:0]   dec_strobes;
    logic               dec_mem, dec_branch, dec_cond, dec_stop, dec_illegal;

    five_op_decoder u_dec (
        .opcode     (ir_reg[INS_W-1 -: OP_W]),
        .strobes    (dec_strobes),
        .is_mem     (dec_mem),
        .is_branch  (dec_branch),
        .is_cond    (dec_cond),
        .is_stop    (dec_stop),
        .is_illegal (dec_illegal)
    );

`ifdef FIVE_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    logic illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_DECODE && dec_illegal) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal = illegal_reg;
`else
    localparam bit TRAP_EN = 1'b0;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_VAL;
            ir_reg     <= '0;
            stb_reg    <= '0;
            re_reg     <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            stb_reg    <= stb_next;
            re_reg     <= re_next;
            halted_reg <= halted_next;
        end
    end

    // Strobes are computed one state ahead so they are registered and visible
    // only during the MEM (read) or EXEC (operation) cycle.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        stb_next    = '0;
        re_next     = 1'b0;
        halted_next = halted_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pc_next    = RESET_VAL;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_next    = ins;
                pc_next    = pc_reg + PC_W'(1);
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_stop || (TRAP_EN && dec_illegal)) begin
                    halted_next = 1'b1;
                    state_next  = ST_HALT;
                end else if (dec_mem) begin
                    re_next    = 1'b1;
                    state_next = ST_MEM;
                end else begin
                    stb_next   = dec_strobes;
                    state_next = ST_EXEC;
                end
            end
            ST_MEM: begin
                stb_next   = dec_strobes;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_branch && (!dec_cond || acc_neg)) begin
                    pc_next = ir_reg[PC_W-1:0];
                end
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    pc_next     = RESET_VAL;
                    halted_next = 1'b0;
                    state_next  = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign dmem_addr = ir_reg[PC_W-1:0];
    assign dmem_re   = re_reg;
    assign dmem_we   = stb_reg[STB_WE];
    assign acc_clr   = stb_reg[STB_CLR];
    assign acc_ld    = stb_reg[STB_LD];
    assign acc_add   = stb_reg[STB_ADD];
    assign acc_com   = stb_reg[STB_COM];
    assign acc_shr   = stb_reg[STB_SHR];
    assign acc_csl   = stb_reg[STB_CSL];
    assign halted    = halted_reg;

endmodule

// File: tb/tb_five_ctrl_sequencer.sv
// Scoreboard bench for five_ctrl_sequencer: expected strobe events are queued with
// the cycle (relative to start) and PC at which they must appear.
module tb_five_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        acc_neg = 1'b0;
    logic [15:0] ins;
    logic [11:0] pc;
    logic [15:0] ir;
    logic [11:0] dmem_addr;
    logic        dmem_re, dmem_we, acc_clr, acc_ld, acc_add, acc_com, acc_shr, acc_csl;
    logic        halted, illegal;

    logic [15:0] imem [0:4095];
    assign ins = imem[pc];

    always #5 clk = ~clk;

    five_ctrl_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ins       (ins),
        .acc_neg   (acc_neg),
        .pc        (pc),
        .ir        (ir),
        .dmem_addr (dmem_addr),
        .dmem_re   (dmem_re),
        .dmem_we   (dmem_we),
        .acc_clr   (acc_clr),
        .acc_ld    (acc_ld),
        .acc_add   (acc_add),
        .acc_com   (acc_com),
        .acc_shr   (acc_shr),
        .acc_csl   (acc_csl),
        .halted    (halted),
        .illegal   (illegal)
    );

    localparam logic [7:0] S_RE  = 8'h80;
    localparam logic [7:0] S_WE  = 8'h40;
    localparam logic [7:0] S_CLR = 8'h20;
    localparam logic [7:0] S_LD  = 8'h10;
    localparam logic [7:0] S_ADD = 8'h08;
    localparam logic [7:0] S_COM = 8'h04;
    localparam logic [7:0] S_SHR = 8'h02;
    localparam logic [7:0] S_CSL = 8'h01;

    typedef struct {
        string       tag;
        logic [7:0]  stb;
        logic [11:0] addr;
        logic [11:0] pc;
        int          rel;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    logic [7:0] stb_vec;
    assign stb_vec = {dmem_re, dmem_we, acc_clr, acc_ld, acc_add, acc_com, acc_shr, acc_csl};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] stb, input logic [11:0] addr,
                            input logic [11:0] pcv, input int rel);
        exp_t e;
        e.tag = tag; e.stb = stb; e.addr = addr; e.pc = pcv; e.rel = rel;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && stb_vec != 8'h00) begin
            check_value("onehot", 32'($onehot(stb_vec)), 32'd1);
            if (sb.size() == 0) begin
                check_value("unexpected_strobe", 32'(stb_vec), 32'd0);
            end else begin
                e = sb.pop_front();
                $display("txn %s: strobes=%02h addr=%03h pc=%03h cycle=%0d", e.tag, stb_vec,
                         dmem_addr, pc, cyc - start_cyc);
                check_value({e.tag, "_stb"}, 32'(stb_vec), 32'(e.stb));
                check_value({e.tag, "_addr"}, 32'(dmem_addr), 32'(e.addr));
                check_value({e.tag, "_pc"}, 32'(pc), 32'(e.pc));
                check_value({e.tag, "_cycle"}, 32'(cyc - start_cyc), 32'(e.rel));
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 4096; i++) imem[i] = 16'h9000;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input logic [11:0] exp_pc, input logic exp_ill);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        check_value({tag, "_halted"}, 32'(halted), 32'd1);
        check_value({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check_value({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        check_value({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_value({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        clear_imem();
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_pc", 32'(pc), 32'h0);
        check_value("rst_ir", 32'(ir), 32'h0);
        check_value("rst_stb", 32'(stb_vec), 32'h0);
        check_value("rst_halted", 32'(halted), 32'h0);
        check_value("rst_illegal", 32'(illegal), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_value("idle_pc", 32'(pc), 32'h0);

        // Basic program: CLA, LDA 002, ADD 003, STOP
        imem[0] = 16'h0000; imem[1] = 16'h1002; imem[2] = 16'h2003; imem[3] = 16'h9000;
        push_exp("cla", S_CLR, 12'h000, 12'h001, 2);
        push_exp("lda_re", S_RE, 12'h002, 12'h002, 5);
        push_exp("lda", S_LD, 12'h002, 12'h002, 6);
        push_exp("add_re", S_RE, 12'h003, 12'h003, 9);
        push_exp("add", S_ADD, 12'h003, 12'h003, 10);
        start_pulse();
        wait_halt("prog1", 12'h004, 1'b0);
        check_value("prog1_ir", 32'(ir), 32'h9000);

        // Jumps and a taken branch
        clear_imem();
        imem[0] = 16'h8005; imem[5] = 16'h8003; imem[3] = 16'h5000; imem[4] = 16'h8007;
        imem[7] = 16'h7001; imem[1] = 16'h4000; imem[2] = 16'h9000;
        imem[8] = 16'h6009; imem[9] = 16'h9000;
        acc_neg = 1'b1;
        push_exp("csl", S_CSL, 12'h000, 12'h004, 8);
        push_exp("shr_ban_taken", S_SHR, 12'h000, 12'h002, 17);
        start_pulse();
        wait_halt("ban_taken", 12'h003, 1'b0);

        // Same program, branch not taken
        acc_neg = 1'b0;
        push_exp("csl2", S_CSL, 12'h000, 12'h004, 8);
        push_exp("sta_ban_fall", S_WE, 12'h009, 12'h009, 17);
        start_pulse();
        wait_halt("ban_fall", 12'h00A, 1'b0);

        // PC wrap from 0xFFF to 0x000
        clear_imem();
        imem[0] = 16'h8FFF; imem[4095] = 16'h3000;
        push_exp("com_wrap", S_COM, 12'h000, 12'h000, 5);
        start_pulse();
        wait_drain("wrap");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the MEM cycle of an LDA
        clear_imem();
        imem[0] = 16'h1123;
        push_exp("lda_abort_re", S_RE, 12'h123, 12'h001, 2);
        start_pulse();
        wait_drain("lda_abort");
        rst_n = 1'b0;
        #1;
        check_value("abort_stb", 32'(stb_vec), 32'h0);
        check_value("abort_pc", 32'(pc), 32'h0);
        check_value("abort_ir", 32'(ir), 32'h0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_hold_pc", 32'(pc), 32'h0);
        check_value("rst_hold_stb", 32'(stb_vec), 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_value("post_rst_pc", 32'(pc), 32'h0);
        check_value("post_rst_ir", 32'(ir), 32'h0);

        // Illegal opcode
        clear_imem();
        imem[0] = 16'hA000; imem[1] = 16'h0000; imem[2] = 16'h9000;
`ifdef FIVE_CTRL_TRAP_EN
        start_pulse();
        wait_halt("trap", 12'h001, 1'b1);
`else
        push_exp("cla_after_nop", S_CLR, 12'h000, 12'h002, 5);
        start_pulse();
        wait_halt("nop", 12'h003, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
